lane_frame_assembler: RTL
=========================

# lane_frame_assembler

Collects a serial stream of signed DATAWIDTH-bit samples into one parallel frame of LANES samples, plus a per-frame shift amount, and presents it as a registered, held frame. It is the producer that feeds the eight-lane sum/shift averaging datapath: lanes 0..7 map to inputs a..h, and sa_out feeds sa. A fill buffer is double-buffered against the output frame register, so the next frame can be collected while the current one waits for acknowledgment.

## Interface
- DATAWIDTH, 16, sample width in bits (signed).
- LANES, 8, samples per frame. Must be ≥ 2; verified at 8.
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  reset, synchronous and active-low (reset when Rst = 0 at a rising Clk edge).
- in_data  input  DATAWIDTH  signed sample.
- in_valid  input  1  in_data is valid.
- in_first  input  1  qualifies in_data as lane 0 of a new frame.
- in_ready  output  1  block can accept a sample this cycle.
- sa_in  input  8  shift amount, captured with each lane-0 sample.
- frame_data  output  LANES*DATAWIDTH  held frame; lane k occupies bits [k*DATAWIDTH +: DATAWIDTH]; lane 0 (a) is at the LSBs.
- sa_out  output  8  shift amount belonging to frame_data.
- frame_valid  output  1  frame_data/sa_out hold a complete frame.
- frame_ack  input  1  consumer takes the frame.
- resync_err  output  1  one-cycle pulse: a partial frame was discarded.
- frame_cnt  output  8  number of frames delivered; wraps 255 -> 0.

## Operation
- Accept = in_valid & in_ready. Samples are written into the fill buffer at index idx, which is 0..LANES-1.
- On accept with in_first = 1, the sample goes to lane 0, sa_in is latched into the fill sa, and idx becomes 1.
  - If idx was not 0 at that point, the partial frame is dropped and resync_err pulses the next cycle.
- On accept with in_first = 0, the sample goes to lane idx and idx increments.
  - in_first = 0 at idx = 0 is legal. The sample becomes lane 0, and sa_in is also latched.
- The accept at idx = LANES-1 completes the frame, and idx returns to 0. The completed frame then goes one of two ways:
  - If frame_valid = 0, or frame_ack = 1 in the same cycle, the frame loads into frame_data/sa_out at that edge. frame_valid becomes 1 and frame_cnt increments.
  - Otherwise pending is set and in_ready becomes 0.
- While pending = 1:
  - in_ready = 0 and no samples are accepted.
  - On the edge where frame_ack = 1, the pending frame loads into the output registers, frame_valid stays 1, frame_cnt increments, and pending clears.
- frame_ack with frame_valid = 1 and nothing to load: frame_valid goes to 0 at that edge. frame_data keeps its old value, which is don't-care.
- frame_ack with frame_valid = 0 is ignored.
- in_ready = !pending. It does not depend combinationally on frame_ack.
- No arithmetic is done on the data. Samples pass through bit-exact with their sign preserved, and no extension is applied.
- Reset: in_ready = 0 while Rst = 0. After reset, these are all 0: frame_data, sa_out, frame_valid, resync_err, frame_cnt, idx, pending, and the fill buffer; in_ready = 1.
  - Reset in the middle of a frame discards the partial frame and the pending frame with no resync_err.

## Timing
- Latency: the accept edge of the last sample is the edge that asserts frame_valid when the output is free. The frame is visible on the next cycle.
- Throughput: one sample per cycle, sustained, when the consumer acks each frame within LANES cycles.
- Back-to-back frames with frame_ack held at 1: frame_valid stays high and frame_data changes on every completing edge.
- Simultaneous completion and ack: the new frame replaces the old one at the same edge, with no bubble.
- in_first together with the completing sample at idx = LANES-1: in_first wins. The frame is not completed; the sample starts a new frame and resync_err pulses.
- All outputs are registered except in_ready, which is decoded from the pending register.

## Test plan
- Reset: hold Rst = 0 for 3 cycles with in_valid = 1 -> all outputs 0 and in_ready = 0. On release, in_ready = 1 and nothing has been accepted.
- Single frame: send samples 1, -2, 3, -4, 5, -6, 7, 0x8000 with in_first on the first, sa_in = 3, frame_ack = 0 -> one cycle after the 8th accept:
  - frame_valid = 1, lane 0 = 0x0001, lane 1 = 0xFFFE, lane 7 = 0x8000;
  - sa_out = 3, frame_cnt = 1, in_ready = 1.
- Backpressure: with frame 1 held unacked, stream a second full frame (sa_in = 5) -> in_ready = 0 after its 8th accept and frame 1 stays intact. Pulse frame_ack -> frame 2 loads at that edge, frame_valid stays 1, sa_out = 5, in_ready returns to 1, frame_cnt = 2.
- Resync: after 3 samples, assert in_first with 0x1234 -> resync_err is high for exactly 1 cycle, and the next completed frame has lane 0 = 0x1234.
- Streaming: 20 frames at 1 sample per cycle with frame_ack tied to 1 -> in_ready never drops, and each frame matches the model. With 256+ frames, frame_cnt wraps 255 -> 0.
- Reset mid-frame: drop Rst after 5 samples while a pending frame exists -> frame_valid = 0, frame_cnt = 0, and the next 8 samples form a clean frame.

Source files
------------

// File: rtl/lane_frame_assembler.sv
// lane_frame_assembler
// Gathers a serial stream of signed samples into one parallel frame of LANES
// samples plus a per-frame shift amount. The frame is presented as a held,
// registered output. A fill buffer is double-buffered against the output
// register, so the next frame can be collected while the consumer still owns
// the current one.

module lane_frame_assembler #(
    parameter int DATAWIDTH = 16,
    parameter int LANES     = 8
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic signed [DATAWIDTH-1:0]   in_data,
    input  logic                          in_valid,
    input  logic                          in_first,
    output logic                          in_ready,
    input  logic [7:0]                    sa_in,
    output logic [LANES*DATAWIDTH-1:0]    frame_data,
    output logic [7:0]                    sa_out,
    output logic                          frame_valid,
    input  logic                          frame_ack,
    output logic                          resync_err,
    output logic [7:0]                    frame_cnt
);

    localparam int IW = (LANES > 2) ? $clog2(LANES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

    // Fill-side state: the buffer being collected, its shift amount, the
    // next lane to write, and whether a completed frame is parked in it.
    logic [LANES*DATAWIDTH-1:0] fill_buf;
    logic [7:0]                 fill_sa;
    logic [IW-1:0]              idx;
    logic                       pending;

    // Decoded per-cycle events.
    logic          accept;
    logic [IW-1:0] wr_idx;
    logic          start_frame;
    logic          complete;
    logic          load_direct;
    logic          load_pending;
    logic [LANES*DATAWIDTH-1:0] completed_frame;

    // The block stops taking samples only while a finished frame is parked or
    // while reset is held. It never looks at frame_ack, so there is no comb
    // path from the consumer back to the producer.
    assign in_ready = Rst & ~pending;

    // Decode the accept, the write lane and the two ways a frame can reach the
    // output register.
    always_comb begin
        accept          = in_valid & in_ready;
        wr_idx          = in_first ? '0 : idx;
        start_frame     = accept & (in_first | (idx == '0));
        complete        = accept & ~in_first & (idx == LAST_IDX);
        load_direct     = complete & (~frame_valid | frame_ack);
        load_pending    = pending & frame_ack;
        completed_frame = {in_data, fill_buf[(LANES-1)*DATAWIDTH-1:0]};
    end

    // Fill buffer, lane index and pending flag. A completed frame that cannot
    // go straight to the output stays in the fill buffer until it is acked.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            fill_buf <= '0;
            fill_sa  <= '0;
            idx      <= '0;
            pending  <= 1'b0;
        end else begin
            if (accept) begin
                fill_buf[int'(wr_idx)*DATAWIDTH +: DATAWIDTH] <= in_data;
                if (start_frame) begin
                    fill_sa <= sa_in;
                end
                if (complete) begin
                    idx <= '0;
                end else begin
                    idx <= wr_idx + IW'(1);
                end
            end
            if (complete && !load_direct) begin
                pending <= 1'b1;
            end else if (load_pending) begin
                pending <= 1'b0;
            end
        end
    end

    // Output frame register, its shift amount, the valid flag, the frame
    // counter and the one-cycle resync pulse for a dropped partial frame.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            frame_data  <= '0;
            sa_out      <= '0;
            frame_valid <= 1'b0;
            resync_err  <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            resync_err <= accept & in_first & (idx != '0);
            if (load_direct) begin
                frame_data  <= completed_frame;
                sa_out      <= fill_sa;
                frame_valid <= 1'b1;
                frame_cnt   <= frame_cnt + 8'd1;
            end else if (load_pending) begin
                frame_data  <= fill_buf;
                sa_out      <= fill_sa;
                frame_valid <= 1'b1;
                frame_cnt   <= frame_cnt + 8'd1;
            end else if (frame_ack && frame_valid) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule
